// File: rtl/slot_write_sched_if.sv
// -----------------------------------------------------------------------------
// slot_write_sched_if
//
// Bundles the slot index stream, the host write request channel and the
// parameter-memory write port of slot_write_sched.
//
// Request handshake: the host holds req_voice/req_env/req_data stable while
// req_valid is high. A request is accepted on a rising edge where both
// req_valid and req_ready are high. req_ready depends only on FIFO occupancy,
// never on req_valid.
//
// Signals:
//   xxxx, xxxx_zero       slot index and end-of-frame marker (timing generator)
//   req_valid/req_ready   host write request handshake
//   req_voice/req_env     target voice and envelope
//   req_data              write data
//   slot_we/addr/data     one-cycle write strobe to the parameter memory
//   sync_ok, sync_err     index-stream lock status and sticky discontinuity flag
//   drop_err              one-cycle pulse for a discarded out-of-range request
//
// Modports: slave = scheduler side, master = generator/host side.
// -----------------------------------------------------------------------------
interface slot_write_sched_if #(
    parameter int V_WIDTH = 3,
    parameter int E_WIDTH = 3,
    parameter int D_WIDTH = 16
);
    localparam int S_WIDTH = V_WIDTH + E_WIDTH;

    logic [S_WIDTH-1:0] xxxx;
    logic               xxxx_zero;
    logic               req_valid;
    logic               req_ready;
    logic [V_WIDTH-1:0] req_voice;
    logic [E_WIDTH-1:0] req_env;
    logic [D_WIDTH-1:0] req_data;
    logic               slot_we;
    logic [S_WIDTH-1:0] slot_addr;
    logic [D_WIDTH-1:0] slot_data;
    logic               sync_ok;
    logic               sync_err;
    logic               drop_err;

    modport slave (
        input  xxxx, xxxx_zero, req_valid, req_voice, req_env, req_data,
        output req_ready, slot_we, slot_addr, slot_data, sync_ok, sync_err, drop_err
    );

    modport master (
        output xxxx, xxxx_zero, req_valid, req_voice, req_env, req_data,
        input  req_ready, slot_we, slot_addr, slot_data, sync_ok, sync_err, drop_err
    );
endinterface

// File: rtl/slot_write_sched.sv
// -----------------------------------------------------------------------------
// slot_write_sched
//
// Queues host writes to the time-multiplexed voice/envelope parameter memory
// and releases each one as a single-cycle strobe on the exact slot it targets.
// Also tracks frame lock on the slot index stream.
//
// Ports:
//   sCLK_XVXENVS    clock, rising edge
//   reset_reg_N     asynchronous, active-low reset
//   bus             slot_write_sched_if.slave (index stream, request channel,
//                   write port, status flags)
//   dbg_sync_state  current sync tracker state (0 = UNLOCKED, 1 = LOCKED)
//
// Configuration macro: SLOT_SYNC_CHECK_EN
//   defined   - in LOCKED every sampled index is compared with the expected
//               one; a mismatch sets sticky sync_err and drops to UNLOCKED.
//   undefined - the tracker locks at the first qualifying end-of-frame and
//               stays locked until reset; sync_err is tied low.
// -----------------------------------------------------------------------------
module slot_write_sched #(
    parameter int VOICES  = 8,
    parameter int V_ENVS  = 8,
    parameter int V_WIDTH = 3,
    parameter int E_WIDTH = 3,
    parameter int D_WIDTH = 16,
    parameter int FIFO_AW = 2
) (
    input  logic                sCLK_XVXENVS,
    input  logic                reset_reg_N,
    slot_write_sched_if.slave   bus,
    output logic                dbg_sync_state
);
    localparam int S_WIDTH = V_WIDTH + E_WIDTH;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam logic [S_WIDTH-1:0] LAST_SLOT = S_WIDTH'(VOICES * V_ENVS - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } sync_state_t;

    sync_state_t state;
    logic        sync_ok_r;
    logic        sync_err_r;

    // FIFO storage: target slot and data per entry
    logic [S_WIDTH-1:0] fifo_slot [DEPTH];
    logic [D_WIDTH-1:0] fifo_data [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    logic               full;
    logic               empty;
    logic               in_range;
    logic               accept;
    logic               push;
    logic               pop;
    logic               frame_end;
    logic [S_WIDTH-1:0] target_slot;

    assign full  = (count == (FIFO_AW+1)'(DEPTH));
    assign empty = (count == '0);

    assign bus.req_ready = ~full;

    // One extra bit on each side so VOICES == 2**V_WIDTH still compares correctly
    assign in_range = ({1'b0, bus.req_voice} < (V_WIDTH+1)'(VOICES)) &&
                      ({1'b0, bus.req_env}   < (E_WIDTH+1)'(V_ENVS));

    // Modulo-2**S_WIDTH arithmetic gives the required truncation for free
    assign target_slot = S_WIDTH'(bus.req_voice) * S_WIDTH'(V_ENVS) + S_WIDTH'(bus.req_env);

    // An out-of-range request is still consumed so the host never stalls on it
    assign accept    = bus.req_valid & ~full;
    assign push      = accept & in_range;
    assign pop       = (state == LOCKED) & ~empty & (bus.xxxx == fifo_slot[rd_ptr]);
    assign frame_end = bus.xxxx_zero & (bus.xxxx == LAST_SLOT);

    // ------------------------------------------------------------------
    // Sync tracker FSM
    // ------------------------------------------------------------------
`ifdef SLOT_SYNC_CHECK_EN
    logic [S_WIDTH-1:0] expected;

    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state      <= UNLOCKED;
            sync_ok_r  <= 1'b0;
            sync_err_r <= 1'b0;
            expected   <= '0;
        end else if (state == UNLOCKED) begin
            if (frame_end) begin
                state     <= LOCKED;
                sync_ok_r <= 1'b1;
                expected  <= '0;
            end
        end else begin
            if (bus.xxxx != expected) begin
                state      <= UNLOCKED;
                sync_ok_r  <= 1'b0;
                sync_err_r <= 1'b1;
            end else if (expected == LAST_SLOT) begin
                expected <= '0;
            end else begin
                expected <= expected + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state     <= UNLOCKED;
            sync_ok_r <= 1'b0;
        end else if (state == UNLOCKED && frame_end) begin
            state     <= LOCKED;
            sync_ok_r <= 1'b1;
        end
    end

    assign sync_err_r = 1'b0;
`endif

    assign bus.sync_ok  = sync_ok_r;
    assign bus.sync_err = sync_err_r;
    assign dbg_sync_state = state;

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge sCLK_XVXENVS) begin
        if (push) begin
            fifo_slot[wr_ptr] <= target_slot;
            fifo_data[wr_ptr] <= bus.req_data;
        end
    end

    // ------------------------------------------------------------------
    // Registered write port and drop pulse
    // ------------------------------------------------------------------
    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            bus.slot_we   <= 1'b0;
            bus.slot_addr <= '0;
            bus.slot_data <= '0;
            bus.drop_err  <= 1'b0;
        end else begin
            bus.slot_we  <= pop;
            bus.drop_err <= accept & ~in_range;
            if (pop) begin
                bus.slot_addr <= fifo_slot[rd_ptr];
                bus.slot_data <= fifo_data[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_slot_write_sched.sv
// -----------------------------------------------------------------------------
// tb_slot_write_sched
//
// Main instance (8x8): free-running slot generator with occasional index
// jumps, randomized host requests, checked each cycle against a queue-based
// reference model. A mid-run reset is applied while a strobe is high.
// Second instance (VOICES=6): directed out-of-range drop and release check.
// -----------------------------------------------------------------------------
module tb_slot_write_sched;
    localparam int VOICES = 8;
    localparam int V_ENVS = 8;
    localparam int VW     = 3;
    localparam int EW     = 3;
    localparam int DW     = 16;
    localparam int SW     = VW + EW;
    localparam int NSLOT  = VOICES * V_ENVS;
    localparam int LAST   = NSLOT - 1;
    localparam int DEPTH  = 4;
    localparam int NCYC   = 6000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    slot_write_sched_if #(.V_WIDTH(VW), .E_WIDTH(EW), .D_WIDTH(DW)) bus ();
    slot_write_sched_if #(.V_WIDTH(VW), .E_WIDTH(EW), .D_WIDTH(DW)) bus6 ();
    logic dbg_state;
    logic dbg_state6;

    slot_write_sched #(
        .VOICES(VOICES), .V_ENVS(V_ENVS), .V_WIDTH(VW), .E_WIDTH(EW),
        .D_WIDTH(DW), .FIFO_AW(2)
    ) u_dut (
        .sCLK_XVXENVS   (clk),
        .reset_reg_N    (rst_n),
        .bus            (bus.slave),
        .dbg_sync_state (dbg_state)
    );

    slot_write_sched #(
        .VOICES(6), .V_ENVS(8), .V_WIDTH(VW), .E_WIDTH(EW),
        .D_WIDTH(DW), .FIFO_AW(2)
    ) u_dut6 (
        .sCLK_XVXENVS   (clk),
        .reset_reg_N    (rst_n),
        .bus            (bus6.slave),
        .dbg_sync_state (dbg_state6)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending writes as {slot, data} in arrival order
    logic [SW+DW-1:0] exp_q[$];
    bit               m_locked;
    bit               m_err;
    int               m_next;
    bit               m_we;
    logic [SW-1:0]    m_addr;
    logic [DW-1:0]    m_data;
    bit               m_drop;
    bit               m_accepted;

    task automatic model_reset();
        exp_q.delete();
        m_locked   = 0;
        m_err      = 0;
        m_next     = 0;
        m_we       = 0;
        m_drop     = 0;
        m_accepted = 0;
    endtask

    // One rising edge of behaviour, using the inputs held across that edge
    task automatic model_step();
        int x;
        int v;
        int e;
        bit room;
        bit was_locked;
        logic [SW+DW-1:0] head;
        x          = int'(bus.xxxx);
        v          = int'(bus.req_voice);
        e          = int'(bus.req_env);
        room       = exp_q.size() < DEPTH;
        was_locked = m_locked;
        m_we       = 0;
        m_drop     = 0;

        if (was_locked && exp_q.size() > 0) begin
            head = exp_q[0];
            if (int'(head[SW+DW-1:DW]) == x) begin
                m_we = 1;
                {m_addr, m_data} = exp_q.pop_front();
            end
        end

        m_accepted = bus.req_valid && room;
        if (m_accepted) begin
            if (v < VOICES && e < V_ENVS)
                exp_q.push_back({SW'((v * V_ENVS + e) % (1 << SW)), bus.req_data});
            else
                m_drop = 1;
        end

        if (!was_locked) begin
            if (bus.xxxx_zero && x == LAST) begin
                m_locked = 1;
                m_next   = 0;
            end
        end else begin
`ifdef SLOT_SYNC_CHECK_EN
            if (x != m_next) begin
                m_locked = 0;
                m_err    = 1;
            end else begin
                m_next = (m_next + 1) % NSLOT;
            end
`endif
        end
    endtask

    task automatic compare_outputs();
        check_val("slot_we", 32'(bus.slot_we), 32'(m_we));
        if (m_we) begin
            check_val("slot_addr", 32'(bus.slot_addr), 32'(m_addr));
            check_val("slot_data", 32'(bus.slot_data), 32'(m_data));
        end
        check_val("drop_err", 32'(bus.drop_err), 32'(m_drop));
        check_val("sync_ok", 32'(bus.sync_ok), 32'(m_locked));
        check_val("dbg_state", 32'(dbg_state), 32'(m_locked));
        check_val("sync_err", 32'(bus.sync_err), 32'(m_err));
        check_val("req_ready", 32'(bus.req_ready), 32'(exp_q.size() < DEPTH));
    endtask

    // ---------------- driver tasks ----------------
    int gx;
    int frame;
    int holdoff;
    int rate;

    task automatic drive_generator();
        int nx;
        if ((frame == 5 && gx == 30) || $urandom_range(0, 2999) == 0)
            nx = (gx + 2) % NSLOT;
        else
            nx = (gx + 1) % NSLOT;
        if (nx < gx) frame++;
        gx = nx;
        bus.xxxx      = SW'(gx);
        bus.xxxx_zero = (gx == LAST);
    endtask

    // A request that was not accepted is held unchanged
    task automatic drive_request();
        if (holdoff > 0) begin
            holdoff--;
            bus.req_valid = 1'b0;
        end else if (!bus.req_valid || m_accepted) begin
            if ($urandom_range(0, 99) < rate) begin
                bus.req_valid = 1'b1;
                bus.req_voice = VW'($urandom_range(0, 7));
                bus.req_env   = EW'($urandom_range(0, 7));
                bus.req_data  = DW'($urandom);
            end else begin
                bus.req_valid = 1'b0;
            end
        end
    endtask

    // Called at a negedge while the strobe is high; returns at a negedge
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check_val("rst_slot_we", 32'(bus.slot_we), 32'd0);
        check_val("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_val("rst_sync_ok", 32'(bus.sync_ok), 32'd0);
        check_val("rst_slot_addr", 32'(bus.slot_addr), 32'd0);
        model_reset();
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        holdoff = 80;
    endtask

    // ---------------- main sequence ----------------
    bit rst_done;

    initial begin
        rst_n          = 1'b0;
        bus.xxxx       = '0;
        bus.xxxx_zero  = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_voice  = '0;
        bus.req_env    = '0;
        bus.req_data   = '0;
        bus6.xxxx      = '0;
        bus6.xxxx_zero = 1'b0;
        bus6.req_valid = 1'b0;
        bus6.req_voice = '0;
        bus6.req_env   = '0;
        bus6.req_data  = '0;
        gx       = LAST;
        frame    = 0;
        holdoff  = 0;
        rate     = 90;
        rst_done = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check_val("init_slot_we", 32'(bus.slot_we), 32'd0);
        check_val("init_slot_addr", 32'(bus.slot_addr), 32'd0);
        check_val("init_slot_data", 32'(bus.slot_data), 32'd0);
        check_val("init_sync_ok", 32'(bus.sync_ok), 32'd0);
        check_val("init_sync_err", 32'(bus.sync_err), 32'd0);
        check_val("init_drop_err", 32'(bus.drop_err), 32'd0);
        check_val("init_req_ready", 32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;

        // First request lands before any end-of-frame: must wait for lock
        bus.req_valid = 1'b1;
        bus.req_voice = 3'd2;
        bus.req_env   = 3'd5;
        bus.req_data  = 16'h1234;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            case ((cyc / 500) % 3)
                0:       rate = 90;
                1:       rate = 30;
                default: rate = 60;
            endcase
            if (!rst_done && cyc >= 3000 && m_we && (exp_q.size() >= 3 || cyc >= 4000)) begin
                rst_done = 1;
                reset_pulse();
            end
            drive_generator();
            drive_request();
            @(posedge clk);
            #1;
            model_step();
            compare_outputs();
            @(negedge clk);
        end
        check_val("reset_mid_run_done", 32'(rst_done), 32'd1);

        // VOICES=6 instance: voice 7 is dropped, slot 47 is released later
        bus.req_valid = 1'b0;
        for (int c = 0; c <= 150; c++) begin
            bus6.xxxx      = SW'(c % 48);
            bus6.xxxx_zero = ((c % 48) == 47);
            if (c == 3) begin
                bus6.req_valid = 1'b1;
                bus6.req_voice = 3'd7;
                bus6.req_env   = 3'd3;
                bus6.req_data  = 16'hBEEF;
            end else if (c == 100) begin
                bus6.req_valid = 1'b1;
                bus6.req_voice = 3'd5;
                bus6.req_env   = 3'd7;
                bus6.req_data  = 16'h5A5A;
            end else begin
                bus6.req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check_val("v6_drop_err", 32'(bus6.drop_err), 32'(c == 3));
            check_val("v6_slot_we", 32'(bus6.slot_we), 32'(c == 143));
            check_val("v6_req_ready", 32'(bus6.req_ready), 32'd1);
            if (c == 143) begin
                check_val("v6_slot_addr", 32'(bus6.slot_addr), 32'd47);
                check_val("v6_slot_data", 32'(bus6.slot_data), 32'h5A5A);
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
